rtl_responder: RTL and testbench

RTL_RESPONDER -- requirements
Module: rtl_responder

---
 rtl/rtl_responder_pkg.sv | 26 ++
 rtl/rtl_responder_fifo.sv | 60 ++++++
 rtl/rtl_responder.sv | 126 ++++++++++++
 tb/tb_rtl_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rtl_responder_pkg.sv
// Shared types and defaults for the rtl_responder block.
//   result_t        : one buffered result {data = in1^in2, any = |in1, all = &in1}
//   DEFAULT_DEPTH   : default result buffer depth (power of two, >= 2)
//   DEFAULT_STALL_EVERY : default throttle period (0 = no throttling)
//   compute_result  : combinational result for one operand pair
package rtl_responder_pkg;

  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_STALL_EVERY = 0;

  typedef struct packed {
    logic [3:0] data;
    logic       any;
    logic       all;
  } result_t;

  function automatic result_t compute_result(input logic [3:0] a,
                                             input logic [3:0] b);
    result_t r;
    r.data = a ^ b;
    r.any  = |a;
    r.all  = &a;
    return r;
  endfunction

endpackage

// File: rtl/rtl_responder_fifo.sv
// DEPTH-entry synchronous FIFO of result_t.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i         : write wr_data_i at the tail (caller guarantees !full_o)
//   wr_data_i      : result to store
//   pop_i          : drop the head entry (caller guarantees !empty_o)
//   rd_data_o      : head entry, forced to zero while empty
//   full_o/empty_o : occupancy flags
module rtl_responder_fifo
  import rtl_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  result_t wr_data_i,
  input  logic    pop_i,
  output result_t rd_data_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  result_t     mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is visible until a pointer moves.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Gate the head so stale storage never shows while empty (zero after reset).
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/rtl_responder.sv
// Valid/ready responder: accepts operand pairs, buffers {in1^in2, |in1, &in1}
// and presents the oldest result downstream.
// Ports:
//   CLK, ASYNCRESETN      : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake, in1/in2 operands
//   out_valid/out_ready   : downstream handshake
//   out_data/out_any/out_all : fields of the oldest buffered result
//   acc_cnt               : 8-bit wrapping count of accepted transfers
//   proto_err             : sticky upstream protocol-violation flag
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready never depends on in_valid; once in_valid is raised
// upstream must hold it and keep in1/in2 stable until accepted.
module rtl_responder
  import rtl_responder_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int STALL_EVERY = DEFAULT_STALL_EVERY
) (
  input  logic       CLK,
  input  logic       ASYNCRESETN,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_any,
  output logic       out_all,
  output logic [7:0] acc_cnt,
  output logic       proto_err
);

  localparam int SW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
  localparam logic [SW-1:0] STALL_LAST =
    SW'((STALL_EVERY > 0) ? STALL_EVERY - 1 : 0);

  logic    fifo_full, fifo_empty;
  logic    accept, pop;
  result_t head;

  // Held low through reset so in_ready rises on the first edge after release.
  logic          ready_en_q;
  logic          stall_q, stall_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]    acc_cnt_q, acc_cnt_d;
  logic          err_q, err_d;
  logic          pend_q, pend_d;
  logic [3:0]    prev_in1_q, prev_in2_q;

  assign in_ready  = ready_en_q & ~fifo_full & ~stall_q;
  assign accept    = in_valid & in_ready;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  rtl_responder_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (CLK),
    .rst_ni   (ASYNCRESETN),
    .push_i   (accept),
    .wr_data_i(compute_result(in1, in2)),
    .pop_i    (pop),
    .rd_data_o(head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign out_data = head.data;
  assign out_any  = head.any;
  assign out_all  = head.all;

  always_comb begin
    stall_d     = 1'b0;
    stall_cnt_d = stall_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    if (accept) begin
      acc_cnt_d = acc_cnt_q + 8'd1;
      if (STALL_EVERY > 0) begin
        // The STALL_EVERY-th accept arms a single dead cycle and restarts the phase.
        if (stall_cnt_q == STALL_LAST) begin
          stall_d     = 1'b1;
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + SW'(1);
        end
      end
    end
  end

  // A refused request last cycle must reappear unchanged this cycle.
  always_comb begin
    pend_d = in_valid & ~in_ready;
    err_d  = err_q;
    if (pend_q && (!in_valid || in1 != prev_in1_q || in2 != prev_in2_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      ready_en_q  <= 1'b0;
      stall_q     <= 1'b0;
      stall_cnt_q <= '0;
      acc_cnt_q   <= '0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      prev_in1_q  <= '0;
      prev_in2_q  <= '0;
    end else begin
      ready_en_q  <= 1'b1;
      stall_q     <= stall_d;
      stall_cnt_q <= stall_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      prev_in1_q  <= in1;
      prev_in2_q  <= in2;
    end
  end

  assign acc_cnt   = acc_cnt_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_rtl_responder.sv
module tb_rtl_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: DEPTH=4, no throttling
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [3:0] a_in1, a_in2, a_out_data;
  logic       a_out_any, a_out_all, a_proto_err;
  logic [7:0] a_acc_cnt;

  // DUT B: DEPTH=4, STALL_EVERY=3
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [3:0] b_in1, b_in2, b_out_data;
  logic       b_out_any, b_out_all, b_proto_err;
  logic [7:0] b_acc_cnt;

  rtl_responder #(.DEPTH(4), .STALL_EVERY(0)) u_dut_a (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in1(a_in1), .in2(a_in2),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_any(a_out_any), .out_all(a_out_all),
    .acc_cnt(a_acc_cnt), .proto_err(a_proto_err)
  );

  rtl_responder #(.DEPTH(4), .STALL_EVERY(3)) u_dut_b (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in1(b_in1), .in2(b_in2),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_any(b_out_any), .out_all(b_out_all),
    .acc_cnt(b_acc_cnt), .proto_err(b_proto_err)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  // Inputs change 1 time unit after the rising edge; checks happen there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in1 = '0; a_in2 = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in1 = '0; b_in2 = '0; b_out_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_out_valid", a_out_valid, 0);
    check("rst_in_ready",  a_in_ready,  0);
    check("rst_acc_cnt",   a_acc_cnt,   0);
    check("rst_proto_err", a_proto_err, 0);
    check("rst_out_data",  a_out_data,  0);
    check("rst_out_any",   a_out_any,   0);
    check("rst_out_all",   a_out_all,   0);

    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", a_in_ready, 0);
    tick();
    check("rdy_after_edge", a_in_ready, 1);

    // Single transfer F^3
    a_in_valid = 1'b1; a_in1 = 4'hF; a_in2 = 4'h3; a_out_ready = 1'b1;
    #1;
    check("single_no_comb_path", a_out_valid, 0);
    tick();
    a_in_valid = 1'b0;
    check("single_out_valid", a_out_valid, 1);
    check("single_out_data",  a_out_data,  4'hC);
    check("single_out_any",   a_out_any,   1);
    check("single_out_all",   a_out_all,   1);
    check("single_acc_cnt",   a_acc_cnt,   1);
    tick();
    check("single_drained", a_out_valid, 0);

    // Fill: 4 accepted, 5th refused while full
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in1 = 4'(i + 1); a_in2 = 4'h0;
      check("fill_ready", a_in_ready, 1);
      tick();
    end
    a_in1 = 4'h5;
    check("fill_full_ready", a_in_ready, 0);
    check("fill_acc_cnt",    a_acc_cnt,  5);
    check("fill_head",       a_out_data, 4'h1);
    tick();
    check("hold_stable_data", a_out_data, 4'h1);
    check("hold_ready",       a_in_ready, 0);
    a_out_ready = 1'b1;
    #1;
    check("full_pop_same_cycle", a_in_ready, 0);
    tick();
    a_out_ready = 1'b0;
    check("ready_after_pop", a_in_ready, 1);
    check("head_after_pop",  a_out_data, 4'h2);
    tick();
    a_in_valid = 1'b0;
    check("fifth_acc_cnt",  a_acc_cnt,  6);
    check("fifth_full",     a_in_ready, 0);
    check("fill_no_err",    a_proto_err, 0);
    a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_order", a_out_data, 32'(k + 2));
      tick();
    end
    check("drain_empty", a_out_valid, 0);

    // Simultaneous accept and pop with one entry buffered
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in1 = 4'h6; a_in2 = 4'h1;
    tick();
    check("sim_head_data", a_out_data, 4'h7);
    check("sim_head_any",  a_out_any,  1);
    check("sim_head_all",  a_out_all,  0);
    a_in1 = 4'h0; a_in2 = 4'h5; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check("sim_valid",   a_out_valid, 1);
    check("sim_data",    a_out_data,  4'h5);
    check("sim_any",     a_out_any,   0);
    check("sim_all",     a_out_all,   0);
    check("sim_acc_cnt", a_acc_cnt,   8);
    tick();
    check("sim_drained", a_out_valid, 0);

    // Protocol error: operand change while refused
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in1 = 4'h1; a_in2 = 4'h0;
    repeat (4) tick();
    check("perr_full_acc", a_acc_cnt, 12);
    check("perr_refused",  a_in_ready, 0);
    tick();
    a_in1 = 4'h2;
    check("perr_not_yet", a_proto_err, 0);
    tick();
    check("perr_set", a_proto_err, 1);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (4) tick();
    check("perr_drained", a_out_valid, 0);
    check("perr_sticky",  a_proto_err, 1);
    rst_n = 1'b0;
    #1;
    check("perr_cleared_by_reset", a_proto_err, 0);
    check("perr_reset_acc",        a_acc_cnt,   0);
    tick();
    rst_n = 1'b1;
    tick();
    check("perr_ready_again", a_in_ready, 1);

    // acc_cnt wrap after 256 accepts
    a_in_valid = 1'b1; a_in1 = 4'hA; a_in2 = 4'h5; a_out_ready = 1'b1;
    repeat (255) tick();
    check("wrap_255", a_acc_cnt, 8'hFF);
    tick();
    check("wrap_0", a_acc_cnt, 0);
    a_in_valid = 1'b0;
    tick();
    check("wrap_drained", a_out_valid, 0);

    // Reset with two entries buffered
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    repeat (2) tick();
    a_in_valid = 1'b0;
    check("mid_buffered", a_out_valid, 1);
    check("mid_acc_cnt",  a_acc_cnt,   2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", a_out_valid, 0);
    check("mid_rst_in_ready",  a_in_ready,  0);
    check("mid_rst_acc_cnt",   a_acc_cnt,   0);
    check("mid_rst_out_data",  a_out_data,  0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rel_not_ready", a_in_ready, 0);
    tick();
    check("mid_rel_ready",     a_in_ready,  1);
    check("mid_rel_discarded", a_out_valid, 0);

    // Throttle on DUT B: 1,1,1,0 repeating
    b_in_valid = 1'b1; b_in1 = 4'h3; b_in2 = 4'h5; b_out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check("thr_ready", b_in_ready, (c % 4 == 3) ? 0 : 1);
      tick();
    end
    b_in_valid = 1'b0;
    check("thr_acc_cnt", b_acc_cnt,   6);
    check("thr_no_err",  b_proto_err, 0);
    check("thr_drained", b_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
